// File: rtl/risc_fetch_sequencer_pkg.sv
// Shared types and sizing for the RISC fetch-stage PC sequencer.
//   seq_state_t : externally visible sequencer state (RUN/STALL/FLUSH/HALT)
//   in_imem     : true when an address falls inside instruction memory
package risc_fetch_sequencer_pkg;

    localparam int unsigned PC_W        = 8;
    localparam int unsigned IMEM_DEPTH  = 100;
    localparam int unsigned FLUSH_SLOTS = 2;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned FLUSH_W     = 2;

    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_STALL = 2'd1,
        SEQ_FLUSH = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_t;

    function automatic logic in_imem(input logic [PC_W-1:0] addr);
        return 32'(addr) < IMEM_DEPTH;
    endfunction

endpackage

// File: rtl/risc_fetch_sequencer_if.sv
// Fetch-sequencer bus: EX redirects, ID stall, halt/resume control, and the
// PC / branch_predict / status returned to RISC_IF.
//   master : pipeline side (drives control, sees PC and status)
//   slave  : the sequencer
interface risc_fetch_sequencer_if;
    import risc_fetch_sequencer_pkg::*;

    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_target;
    logic              halt_req;
    logic              resume;
    logic [PC_W-1:0]   resume_pc;
    logic [PC_W-1:0]   PC1_pre_fetch;
    logic [PC_W-1:0]   PC;
    logic              branch_predict;
    seq_state_t        seq_state;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output stall, redirect_valid, redirect_target, halt_req, resume,
               resume_pc, PC1_pre_fetch,
        input  PC, branch_predict, seq_state, fetch_count
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, halt_req, resume,
               resume_pc, PC1_pre_fetch,
        output PC, branch_predict, seq_state, fetch_count
    );

endinterface

// File: rtl/risc_fetch_sequencer.sv
// Program-counter sequencer for the RISC fetch stage.
//   CLK   : clock, PC updates on posedge
//   reset : asynchronous active-low reset
//   bus   : slave side of risc_fetch_sequencer_if (redirect/stall/halt/resume
//           in; PC, branch_predict, seq_state, fetch_count out)
// Next-PC priority: resume (in HALT) > redirect > halt_req > stall > sequential.
// branch_predict is a decode of state and redirect_valid, so it drops in the
// same cycle a redirect arrives.
module risc_fetch_sequencer
    import risc_fetch_sequencer_pkg::*;
(
    input  logic                    CLK,
    input  logic                    reset,
    risc_fetch_sequencer_if.slave   bus
);

    seq_state_t          state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [FLUSH_W-1:0]  flush_q, flush_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                seq_ok;

    // State, PC and counters
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= SEQ_RUN;
            pc_q    <= '0;
            flush_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state / next PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        seq_ok  = in_imem(bus.PC1_pre_fetch);

        if (state_q == SEQ_HALT) begin
            // Redirects are ignored while halted; only resume restarts fetch.
            if (bus.resume) begin
                pc_d    = bus.resume_pc;
                state_d = SEQ_RUN;
            end
        end else if (bus.redirect_valid) begin
            pc_d    = bus.redirect_target;
            flush_d = FLUSH_W'(FLUSH_SLOTS - 1);
            state_d = SEQ_FLUSH;
        end else if (bus.halt_req) begin
            state_d = SEQ_HALT;
        end else if (state_q == SEQ_FLUSH) begin
            // Stall freezes both PC and the squash countdown.
            if (bus.stall) begin
                if (flush_q == '0) begin
                    state_d = SEQ_STALL;
                end
            end else if (!seq_ok) begin
                state_d = SEQ_HALT;
            end else begin
                pc_d = bus.PC1_pre_fetch;
                if (flush_q == '0) begin
                    state_d = SEQ_RUN;
                end else begin
                    flush_d = flush_q - FLUSH_W'(1);
                end
            end
        end else begin
            // RUN and STALL: the word at PC is valid once it is not stalled.
            if (bus.stall) begin
                state_d = SEQ_STALL;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!seq_ok) begin
                    state_d = SEQ_HALT;
                end else begin
                    pc_d    = bus.PC1_pre_fetch;
                    state_d = SEQ_RUN;
                end
            end
        end
    end

    assign bus.PC             = pc_q;
    assign bus.seq_state      = state_q;
    assign bus.fetch_count    = cnt_q;
    assign bus.branch_predict = ((state_q == SEQ_RUN) || (state_q == SEQ_STALL))
                                && !bus.redirect_valid;

endmodule

// File: tb/tb_risc_fetch_sequencer.sv
// Bench for risc_fetch_sequencer: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_risc_fetch_sequencer;
    import risc_fetch_sequencer_pkg::*;

    localparam int M_RUN   = 0;
    localparam int M_STALL = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state
    int m_pc, m_mode, m_left, m_cnt;

    risc_fetch_sequencer_if bus ();

    assign bus.PC1_pre_fetch = bus.PC + PC_W'(1);

    risc_fetch_sequencer dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rv, input int tgt,
                         input logic hr, input logic rs, input int rpc);
        bus.stall           = st;
        bus.redirect_valid  = rv;
        bus.redirect_target = PC_W'(tgt);
        bus.halt_req        = hr;
        bus.resume          = rs;
        bus.resume_pc       = PC_W'(rpc);
    endtask

    task automatic model_reset();
        m_pc = 0; m_mode = M_RUN; m_left = 0; m_cnt = 0;
    endtask

    // One clock of the fetch rules applied to the current inputs.
    task automatic model_step();
        if (m_mode == M_HALT) begin
            if (bus.resume) begin
                m_pc = int'(bus.resume_pc); m_mode = M_RUN;
            end
        end else if (bus.redirect_valid) begin
            m_pc = int'(bus.redirect_target); m_left = FLUSH_SLOTS - 1; m_mode = M_FLUSH;
        end else if (bus.halt_req) begin
            m_mode = M_HALT;
        end else if (m_mode == M_FLUSH) begin
            if (bus.stall) begin
                if (m_left == 0) m_mode = M_STALL;
            end else if (m_pc + 1 >= IMEM_DEPTH) begin
                m_mode = M_HALT;
            end else begin
                m_pc = m_pc + 1;
                if (m_left == 0) m_mode = M_RUN;
                else m_left = m_left - 1;
            end
        end else if (bus.stall) begin
            m_mode = M_STALL;
        end else begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            if (m_pc + 1 >= IMEM_DEPTH) m_mode = M_HALT;
            else begin
                m_pc = m_pc + 1; m_mode = M_RUN;
            end
        end
    endtask

    function automatic int model_bp();
        return ((m_mode == M_RUN || m_mode == M_STALL) && !bus.redirect_valid) ? 1 : 0;
    endfunction

    // Check outputs mid-cycle, advance the model, then cross one posedge.
    task automatic cycle(input string tag);
        @(negedge clk);
        chk({tag, "_pc"},    32'(bus.PC),             32'(m_pc));
        chk({tag, "_state"}, 32'(bus.seq_state),      32'(m_mode));
        chk({tag, "_bp"},    32'(bus.branch_predict), 32'(model_bp()));
        chk({tag, "_cnt"},   32'(bus.fetch_count),    32'(m_cnt));
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saved_cnt;
        int n;
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        model_reset();
        #12;
        chk("rst_pc",    32'(bus.PC), 0);
        chk("rst_state", 32'(bus.seq_state), 0);
        chk("rst_bp",    32'(bus.branch_predict), 1);
        chk("rst_cnt",   32'(bus.fetch_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: free run from reset
        for (int i = 0; i < 5; i++) cycle("t1");
        chk("t1_pc5",  32'(bus.PC), 5);
        chk("t1_cnt5", 32'(bus.fetch_count), 5);
        chk("t1_bp",   32'(bus.branch_predict), 1);

        // 2: redirect at PC=7 to 10
        cycle("t1b"); cycle("t1b");
        chk("t2_at7", 32'(bus.PC), 7);
        drive(0, 1, 10, 0, 0, 0);
        cycle("t2_redir");
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_pc10", 32'(bus.PC), 10);
        chk("t2_bp0",  32'(bus.branch_predict), 0);
        cycle("t2_f1"); cycle("t2_f2");
        chk("t2_pc12", 32'(bus.PC), 12);
        chk("t2_run",  32'(bus.seq_state), 0);
        chk("t2_bp1",  32'(bus.branch_predict), 1);

        // 3: stall at PC=20
        for (int i = 0; i < 50 && bus.PC != 8'd20; i++) cycle("t3_idle");
        chk("t3_at20", 32'(bus.PC), 20);
        saved_cnt = int'(bus.fetch_count);
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("t3_stall");
        chk("t3_hold",  32'(bus.PC), 20);
        chk("t3_state", 32'(bus.seq_state), 1);
        chk("t3_cnt",   32'(bus.fetch_count), 32'(saved_cnt));
        drive(0, 0, 0, 0, 0, 0);
        cycle("t3_rel");
        chk("t3_pc21", 32'(bus.PC), 21);

        // 4: redirect again while flushing
        drive(0, 1, 60, 0, 0, 0);
        cycle("t4_r1");
        drive(0, 0, 0, 0, 0, 0);
        cycle("t4_f");
        drive(0, 1, 30, 0, 0, 0);
        cycle("t4_r2");
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_pc30", 32'(bus.PC), 30);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.branch_predict) break;
            n++;
            cycle("t4_sq");
        end
        chk("t4_squashed", 32'(n), 2);
        chk("t4_pc32",     32'(bus.PC), 32);

        // 5: run off the end of instruction memory, then resume
        for (int i = 0; i < 200 && bus.seq_state != SEQ_HALT; i++) cycle("t5_run");
        chk("t5_pc99", 32'(bus.PC), 99);
        chk("t5_halt", 32'(bus.seq_state), 3);
        chk("t5_bp0",  32'(bus.branch_predict), 0);
        drive(0, 1, 10, 0, 0, 0);
        cycle("t5_ignred");
        chk("t5_still99", 32'(bus.PC), 99);
        drive(0, 0, 0, 1, 1, 5);
        cycle("t5_resume");
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_pc5", 32'(bus.PC), 5);
        chk("t5_run", 32'(bus.seq_state), 0);

        // 6: asynchronous reset in the middle of a flush
        drive(0, 1, 40, 0, 0, 0);
        cycle("t6_redir");
        drive(0, 0, 0, 0, 0, 0);
        chk("t6_flush", 32'(bus.seq_state), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_pc",    32'(bus.PC), 0);
        chk("t6_state", 32'(bus.seq_state), 0);
        chk("t6_bp",    32'(bus.branch_predict), 1);
        chk("t6_cnt",   32'(bus.fetch_count), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(99, 0) < 20,
                  $urandom_range(99, 0) < 10,
                  int'($urandom_range(IMEM_DEPTH - 1, 0)),
                  $urandom_range(99, 0) < 3,
                  $urandom_range(99, 0) < 30,
                  int'($urandom_range(IMEM_DEPTH - 1, 0)));
            cycle("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
